// File: rtl/sensor_frame_pkg.sv
// sensor_frame_pkg
//   Shared definitions for the sensor frame writer: FSM state encoding,
//   default frame header byte, CRC-8 polynomial and frame size helpers.
//   Used by sensor_frame_writer and frame_crc8.
package sensor_frame_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_CTRL = 4'd1,
        ST_RD_WAIT = 4'd2,
        ST_LATCH   = 4'd3,
        ST_WR_HDR  = 4'd4,
        ST_WR_SEQ  = 4'd5,
        ST_WR_DATA = 4'd6,
        ST_WR_SUM  = 4'd7,
        ST_WR_STAT = 4'd8
    } sfw_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] CRC8_POLY     = 8'h07;

    // Bytes used per channel: CH_W rounded up to whole bytes.
    function automatic int bytes_per_ch(input int ch_w);
        return (ch_w + 7) / 8;
    endfunction

    // Header + seq + payload + checksum.
    function automatic int frame_bytes(input int n_ch, input int ch_w);
        return 2 + n_ch * bytes_per_ch(ch_w) + 1;
    endfunction

endpackage

// File: rtl/frame_crc8.sv
// frame_crc8
//   One-byte step of CRC-8 (poly 0x07, MSB first, no reflection).
//   Ports:
//     crc      in  8  running CRC value
//     data     in  8  byte being absorbed
//     crc_next out 8  CRC after absorbing data
module frame_crc8
    import sensor_frame_pkg::*;
(
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);

    always_comb begin
        crc_next = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[7]) crc_next = {crc_next[6:0], 1'b0} ^ CRC8_POLY;
            else             crc_next = {crc_next[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/sensor_frame_writer.sv
// sensor_frame_writer
//   Periodically snapshots N_CH channels and writes a framed, checksummed
//   record byte-wise into BRAM port B, ping-ponging between two banks and
//   publishing the finished bank in a status byte. Bit 0 of the host
//   control byte pauses sampling.
//   Optional: define SFW_CRC8_EN for a CRC-8 checksum instead of XOR.
//   Ports:
//     clk        in   system clock
//     Rst        in   synchronous active-high reset
//     en         in   sampling enable
//     ch_data    in   channel k at [k*CH_W +: CH_W]
//     ram_addr   out  BRAM port B address
//     ram_wdata  out  BRAM port B write data
//     ram_we     out  BRAM port B write enable
//     ram_rdata  in   BRAM port B read data (1-cycle latency)
//     busy       out  FSM not idle
//     frame_done out  one-cycle pulse per completed frame
//     overrun    out  sticky, a tick arrived while busy
//     seq        out  sequence number of the next frame
module sensor_frame_writer
    import sensor_frame_pkg::*;
#(
    parameter int         N_CH        = 7,
    parameter int         CH_W        = 16,
    parameter int         ADDR_W      = 32,
    parameter int         PERIOD_CYC  = 100000,
    parameter int         CTRL_ADDR   = 'h00,
    parameter int         STAT_ADDR   = 'h01,
    parameter int         BASE_ADDR   = 'h10,
    parameter int         BANK_STRIDE = 'h20,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
    input  logic                 clk,
    input  logic                 Rst,
    input  logic                 en,
    input  logic [N_CH*CH_W-1:0] ch_data,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [7:0]           ram_wdata,
    output logic                 ram_we,
    input  logic [7:0]           ram_rdata,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun,
    output logic [7:0]           seq
);

    localparam int BPC         = bytes_per_ch(CH_W);
    localparam int DATA_BYTES  = N_CH * BPC;
    localparam int FRAME_BYTES = frame_bytes(N_CH, CH_W);
    localparam int CW          = $clog2(DATA_BYTES + 1);
    localparam int TW          = $clog2(PERIOD_CYC + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BYTES - 1);

    localparam logic [3:0] IDLE    = ST_IDLE;
    localparam logic [3:0] RD_CTRL = ST_RD_CTRL;
    localparam logic [3:0] RD_WAIT = ST_RD_WAIT;
    localparam logic [3:0] LATCH   = ST_LATCH;
    localparam logic [3:0] WR_HDR  = ST_WR_HDR;
    localparam logic [3:0] WR_SEQ  = ST_WR_SEQ;
    localparam logic [3:0] WR_DATA = ST_WR_DATA;
    localparam logic [3:0] WR_SUM  = ST_WR_SUM;
    localparam logic [3:0] WR_STAT = ST_WR_STAT;

    logic [3:0]              state;
    logic [TW-1:0]           tcnt;
    logic                    tick;
    logic                    bank;
    logic [CW-1:0]           cnt;
    logic [7:0]              sum;
    logic [7:0]              sum_next;
    logic [DATA_BYTES*8-1:0] data_sr;
    logic [DATA_BYTES*8-1:0] snap_bytes;
    logic [BPC*8-1:0]        ch_pad;
    logic [ADDR_W-1:0]       base;
    logic                    unused_ctrl;

    // Only the pause bit of the control byte is defined.
    assign unused_ctrl = ^ram_rdata[7:1];

    assign tick = en && (tcnt == TW'(PERIOD_CYC - 1));
    assign busy = (state != IDLE);
    assign base = bank ? ADDR_W'(BASE_ADDR + BANK_STRIDE) : ADDR_W'(BASE_ADDR);

    // Payload laid out so the first byte to send sits at the top:
    // channel 0 first, each channel zero-extended and MSB byte first.
    always_comb begin
        snap_bytes = '0;
        ch_pad     = '0;
        for (int k = 0; k < N_CH; k++) begin
            ch_pad             = '0;
            ch_pad[CH_W-1:0]   = ch_data[k*CH_W +: CH_W];
            snap_bytes[(N_CH-1-k)*BPC*8 +: BPC*8] = ch_pad;
        end
    end

`ifdef SFW_CRC8_EN
    frame_crc8 u_crc (.crc(sum), .data(ram_wdata), .crc_next(sum_next));
`else
    assign sum_next = sum ^ ram_wdata;
`endif

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        case (state)
            // Address held through RD_WAIT so the byte seen in LATCH is ctrl.
            RD_CTRL, RD_WAIT: ram_addr = ADDR_W'(CTRL_ADDR);
            WR_HDR: begin
                ram_addr = base; ram_wdata = SYNC_BYTE; ram_we = 1'b1;
            end
            WR_SEQ: begin
                ram_addr = base + ADDR_W'(1); ram_wdata = seq; ram_we = 1'b1;
            end
            WR_DATA: begin
                ram_addr  = base + ADDR_W'(cnt) + ADDR_W'(2);
                ram_wdata = data_sr[DATA_BYTES*8-1 -: 8];
                ram_we    = 1'b1;
            end
            WR_SUM: begin
                ram_addr = base + ADDR_W'(FRAME_BYTES - 1); ram_wdata = sum; ram_we = 1'b1;
            end
            WR_STAT: begin
                ram_addr = ADDR_W'(STAT_ADDR); ram_wdata = {bank, seq[6:0]}; ram_we = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst)              tcnt <= '0;
        else if (!en || tick) tcnt <= '0;
        else                  tcnt <= tcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state      <= IDLE;
            seq        <= '0;
            bank       <= 1'b0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= '0;
            sum        <= '0;
            data_sr    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (tick && state != IDLE) overrun <= 1'b1;
            if (state == WR_SEQ || state == WR_DATA) sum <= sum_next;
            case (state)
                IDLE:    if (tick) state <= RD_CTRL;
                RD_CTRL: state <= RD_WAIT;
                RD_WAIT: state <= LATCH;
                LATCH: begin
                    data_sr <= snap_bytes;
                    sum     <= '0;
                    cnt     <= '0;
                    state   <= ram_rdata[0] ? IDLE : WR_HDR;
                end
                WR_HDR:  state <= WR_SEQ;
                WR_SEQ:  state <= WR_DATA;
                WR_DATA: begin
                    data_sr <= data_sr << 8;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_IDX) state <= WR_SUM;
                end
                WR_SUM:  state <= WR_STAT;
                WR_STAT: begin
                    frame_done <= 1'b1;
                    bank       <= ~bank;
                    seq        <= seq + 8'd1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_frame_writer.sv
// tb_sensor_frame_writer
//   Three writers side by side: u_a (defaults, 40-cycle period) for frame
//   content, ping-pong, pause and mid-frame reset; u_b (10-cycle period)
//   for overrun; u_c (2 x 12-bit channels) for odd widths. A frame-level
//   model predicts every write, busy, frame_done, overrun and seq per cycle.
module tb_sensor_frame_writer;

    localparam int NI = 3;
    localparam int KS = 1000000;

    function automatic int nch(input int i);    return (i == 2) ? 2 : 7; endfunction
    function automatic int chw(input int i);    return (i == 2) ? 12 : 16; endfunction
    function automatic int per(input int i);    return (i == 0) ? 40 : (i == 1) ? 10 : 30; endfunction
    function automatic int bpc(input int i);    return (chw(i) + 7) / 8; endfunction
    function automatic int fbytes(input int i); return 3 + nch(i) * bpc(i); endfunction

    function automatic logic [7:0] crc8_ref(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int b = 0; b < 8; b++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        return c;
    endfunction

    function automatic logic [7:0] sum_step(input logic [7:0] s, input logic [7:0] d);
`ifdef SFW_CRC8_EN
        return crc8_ref(s, d);
`else
        return s ^ d;
`endif
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        en_v [NI];
    logic        rst_v [NI];
    logic [7:0]  host_ctrl [NI];
    int          chv [NI][7];
    logic [111:0] ch_a, ch_b;
    logic [23:0]  ch_c;
    logic [31:0] addr_o [NI];
    logic [7:0]  wd_o [NI], rd_i [NI], seq_o [NI];
    logic        we_o [NI], busy_o [NI], done_o [NI], ovr_o [NI];
    logic [7:0]  mem [NI][256];

    always_comb begin
        ch_a = '0; ch_b = '0; ch_c = '0;
        for (int k = 0; k < 7; k++) begin
            ch_a[k*16 +: 16] = chv[0][k][15:0];
            ch_b[k*16 +: 16] = chv[1][k][15:0];
        end
        for (int k = 0; k < 2; k++) ch_c[k*12 +: 12] = chv[2][k][11:0];
    end

    sensor_frame_writer #(.PERIOD_CYC(40)) u_a (
        .clk(clk), .Rst(rst_v[0]), .en(en_v[0]), .ch_data(ch_a),
        .ram_addr(addr_o[0]), .ram_wdata(wd_o[0]), .ram_we(we_o[0]), .ram_rdata(rd_i[0]),
        .busy(busy_o[0]), .frame_done(done_o[0]), .overrun(ovr_o[0]), .seq(seq_o[0]));
    sensor_frame_writer #(.PERIOD_CYC(10)) u_b (
        .clk(clk), .Rst(rst_v[1]), .en(en_v[1]), .ch_data(ch_b),
        .ram_addr(addr_o[1]), .ram_wdata(wd_o[1]), .ram_we(we_o[1]), .ram_rdata(rd_i[1]),
        .busy(busy_o[1]), .frame_done(done_o[1]), .overrun(ovr_o[1]), .seq(seq_o[1]));
    sensor_frame_writer #(.N_CH(2), .CH_W(12), .PERIOD_CYC(30)) u_c (
        .clk(clk), .Rst(rst_v[2]), .en(en_v[2]), .ch_data(ch_c),
        .ram_addr(addr_o[2]), .ram_wdata(wd_o[2]), .ram_we(we_o[2]), .ram_rdata(rd_i[2]),
        .busy(busy_o[2]), .frame_done(done_o[2]), .overrun(ovr_o[2]), .seq(seq_o[2]));

    // BRAM port B: registered read; address 0 returns the host control byte.
    always @(posedge clk)
        for (int i = 0; i < NI; i++) begin
            rd_i[i] <= (addr_o[i][7:0] == 8'h00) ? host_ctrl[i] : mem[i][addr_o[i][7:0]];
            if (we_o[i]) mem[i][addr_o[i][7:0]] <= wd_o[i];
        end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input int i, input string nm, input longint act, input longint exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL u%0d %s @cyc %0d: got %0h, expected %0h", i, nm, cyc, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    int run [NI], busy_from [NI], busy_until [NI], snap_at [NI], done_at [NI];
    int ovr_from [NI], seq_m [NI], bank_m [NI], first_done [NI];
    int         exp_a [int];
    logic [7:0] exp_d [int];

    task automatic build_frame(input int i, input int start);
        logic [7:0] b [$];
        logic [7:0] s;
        int base;
        base = 'h10 + bank_m[i] * 'h20;
        s = 8'(seq_m[i]);
        b.push_back(8'hA5);
        b.push_back(s);
        for (int k = 0; k < nch(i); k++) begin
            int v;
            v = chv[i][k] & ((1 << chw(i)) - 1);
            for (int j = bpc(i) - 1; j >= 0; j--) begin
                b.push_back(8'((v >> (8 * j)) & 'hFF));
                s = sum_step(s, b[b.size() - 1]);
            end
        end
        b.push_back(s);
        for (int j = 0; j < b.size(); j++) begin
            exp_a[i * KS + start + j] = base + j;
            exp_d[i * KS + start + j] = b[j];
        end
        exp_a[i * KS + start + b.size()] = 1;
        exp_d[i * KS + start + b.size()] = 8'((bank_m[i] << 7) | (seq_m[i] & 'h7F));
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int c, key;
            logic tk, xb, xwe;
            c = cyc;
            key = i * KS + c;
            if (en_v[i]) run[i]++; else run[i] = 0;
            tk = en_v[i] && (run[i] % per(i) == 0);
            if (tk) begin
                if (busy_from[i] >= 0 && c >= busy_from[i] && c <= busy_until[i]) begin
                    if (ovr_from[i] < 0) ovr_from[i] = c + 1;
                end else begin
                    busy_from[i]  = c + 1;
                    busy_until[i] = c + fbytes(i) + 4;
                    snap_at[i]    = c + 3;
                end
            end
            if (c == snap_at[i]) begin
                if (host_ctrl[i][0]) busy_until[i] = c;
                else begin
                    build_frame(i, c + 1);
                    done_at[i] = c + 2 + fbytes(i);
                end
            end
            if (c == done_at[i]) begin
                seq_m[i]  = (seq_m[i] + 1) % 256;
                bank_m[i] = bank_m[i] ^ 1;
            end
            xb  = busy_from[i] >= 0 && c >= busy_from[i] && c <= busy_until[i];
            xwe = exp_d.exists(key);
            chk(i, "ram_we", we_o[i], xwe);
            if (xwe) begin
                chk(i, "ram_addr", addr_o[i], exp_a[key]);
                chk(i, "ram_wdata", wd_o[i], exp_d[key]);
            end else if (!xb) begin
                chk(i, "idle_addr", addr_o[i], 0);
                chk(i, "idle_wdata", wd_o[i], 0);
            end
            chk(i, "busy", busy_o[i], xb);
            chk(i, "frame_done", done_o[i], c == done_at[i]);
            chk(i, "overrun", ovr_o[i], ovr_from[i] >= 0 && c >= ovr_from[i]);
            chk(i, "seq", seq_o[i], seq_m[i]);
            if (done_o[i] && first_done[i] < 0) first_done[i] = c;
            if (rst_v[i]) begin
                for (int k = c + 1; k <= c + 64; k++)
                    if (exp_d.exists(i * KS + k)) begin
                        exp_d.delete(i * KS + k);
                        exp_a.delete(i * KS + k);
                    end
                busy_from[i] = -1; busy_until[i] = -1; snap_at[i] = -1; done_at[i] = -1;
                ovr_from[i] = -1; seq_m[i] = 0; bank_m[i] = 0; run[i] = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] f1 [17];
        logic [7:0] s;
        for (int i = 0; i < NI; i++) begin
            en_v[i] = 1'b0; rst_v[i] = 1'b1; host_ctrl[i] = 8'h00;
            run[i] = 0; busy_from[i] = -1; busy_until[i] = -1; snap_at[i] = -1;
            done_at[i] = -1; ovr_from[i] = -1; seq_m[i] = 0; bank_m[i] = 0; first_done[i] = -1;
            for (int k = 0; k < 7; k++) chv[i][k] = 0;
        end
        for (int k = 0; k < 7; k++) begin
            chv[0][k] = 'h3231 + k * 'h0202;
            chv[1][k] = 'h3231 + k * 'h0202;
        end
        chv[2][0] = 'hABC;
        chv[2][1] = 'h123;

        wait_until(4);
        for (int i = 0; i < NI; i++) begin
            chk(i, "reset_busy", busy_o[i], 0);
            chk(i, "reset_seq", seq_o[i], 0);
            chk(i, "reset_addr", addr_o[i], 0);
            rst_v[i] = 1'b0;
        end
        wait_until(5);
        for (int i = 0; i < NI; i++) en_v[i] = 1'b1;

        // u_b ticks at 14, 24, 34: 24 is the first dropped one.
        wait_until(24);
        chk(1, "overrun_before_drop", ovr_o[1], 0);
        wait_until(25);
        chk(1, "overrun_after_drop", ovr_o[1], 1);

        // u_c frame from tick 34, done at 46.
        wait_until(50);
        chk(2, "c_hdr", mem[2][8'h10], 8'hA5);
        chk(2, "c_seq", mem[2][8'h11], 8'h00);
        chk(2, "c_d0", mem[2][8'h12], 8'h0A);
        chk(2, "c_d1", mem[2][8'h13], 8'hBC);
        chk(2, "c_d2", mem[2][8'h14], 8'h01);
        chk(2, "c_d3", mem[2][8'h15], 8'h23);
`ifdef SFW_CRC8_EN
        s = crc8_ref(crc8_ref(crc8_ref(crc8_ref(crc8_ref(8'h00, 8'h00), 8'h0A), 8'hBC), 8'h01), 8'h23);
`else
        s = 8'h94;
`endif
        chk(2, "c_sum", mem[2][8'h16], s);
        chk(2, "c_stat", mem[2][8'h01], 8'h00);

        // u_a first frame: tick 44, done 66.
        wait_until(70);
        f1 = '{8'hA5, 8'h00, 8'h32, 8'h31, 8'h34, 8'h33, 8'h36, 8'h35, 8'h38,
               8'h37, 8'h3A, 8'h39, 8'h3C, 8'h3B, 8'h3E, 8'h3D, 8'h0F};
`ifdef SFW_CRC8_EN
        s = 8'h00;
        for (int j = 1; j < 16; j++) s = crc8_ref(s, f1[j]);
        f1[16] = s;
`endif
        for (int j = 0; j < 17; j++) chk(0, $sformatf("f1_byte%0d", j), mem[0][8'h10 + j], f1[j]);
        chk(0, "f1_stat", mem[0][8'h01], 8'h00);
        chk(0, "f1_latency", first_done[0] - 44, 22);
        chk(0, "seq_after_f1", seq_o[0], 1);

        // Frame 2 (tick 84) has latched by 87; this change lands in frame 3.
        wait_until(94);
        chv[0][0] = 'hBEEF;
        wait_until(110);
        chk(0, "f2_hdr", mem[0][8'h30], 8'hA5);
        chk(0, "f2_seq", mem[0][8'h31], 8'h01);
        chk(0, "f2_ch0", mem[0][8'h32], 8'h32);
        chk(0, "f2_stat", mem[0][8'h01], 8'h81);
        wait_until(150);
        chk(0, "f3_seq", mem[0][8'h11], 8'h02);
        chk(0, "f3_ch0", mem[0][8'h12], 8'hBE);
        chk(0, "f3_stat", mem[0][8'h01], 8'h02);

        // Pause across tick 164, resume for tick 204.
        host_ctrl[0] = 8'h01;
        wait_until(190);
        chk(0, "pause_seq", seq_o[0], 3);
        chk(0, "pause_stat", mem[0][8'h01], 8'h02);
        host_ctrl[0] = 8'h00;
        wait_until(230);
        chk(0, "resume_seq", seq_o[0], 4);
        chk(0, "resume_stat", mem[0][8'h01], 8'h83);

        // Tick 244: payload writes run 250..263; reset in the middle.
        wait_until(255);
        rst_v[0] = 1'b1;
        wait_until(256);
        rst_v[0] = 1'b0;
        chk(0, "rst_busy", busy_o[0], 0);
        chk(0, "rst_we", we_o[0], 0);
        chk(0, "rst_seq", seq_o[0], 0);
        wait_until(290);
        chk(0, "rst_stat_kept", mem[0][8'h01], 8'h83);
        wait_until(320);
        chk(0, "post_rst_stat", mem[0][8'h01], 8'h00);
        chk(0, "post_rst_seq_byte", mem[0][8'h11], 8'h00);
        chk(0, "post_rst_seq", seq_o[0], 1);
        chk(1, "overrun_sticky", ovr_o[1], 1);

        wait_until(335);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_frame_writer.md
Name: sensor_frame_writer

Overview:
- Parametrised successor to the fixed gyro-to-RAM packer.
- Periodically snapshots N_CH sensor channels of CH_W bits and serialises them into a framed, checksummed record.
- Writes the record byte-wise into port B of the dual-port BRAM that the QSPI slave reads on port A.
- Ping-pongs between two RAM banks and publishes the completed bank in a status byte, so the host never reads a half-written frame; a host-written control byte can pause sampling.

Parameters:
- N_CH, 7, number of sensor channels
- CH_W, 16, bits per channel (1..32)
- ADDR_W, 32, RAM address width
- PERIOD_CYC, 100000, clk cycles between sample ticks (1 kHz at 100 MHz); must be >= FRAME_BYTES+5
- CTRL_ADDR, 'h00, host-written control byte address
- STAT_ADDR, 'h01, status byte address
- BASE_ADDR, 'h10, bank 0 base address
- BANK_STRIDE, 'h20, bank 1 base = BASE_ADDR+BANK_STRIDE; must be >= FRAME_BYTES
- SYNC_BYTE, 'hA5, frame header byte

Ports:
- clk  in  1  system clock (100 MHz domain)
- Rst  in  1  reset; synchronous, active-high
- en  in  1  sampling enable
- ch_data  in  N_CH*CH_W  channel k in bits [k*CH_W +: CH_W]
- ram_addr  out  ADDR_W  BRAM port B address
- ram_wdata  out  8  BRAM port B write data
- ram_we  out  1  BRAM port B write enable
- ram_rdata  in  8  BRAM port B read data; 1-cycle read latency
- busy  out  1  high whenever the FSM is not in IDLE
- frame_done  out  1  one-cycle pulse per completed frame
- overrun  out  1  sticky; set when a tick is dropped
- seq  out  8  sequence number of the next frame

Behaviour:
- Derived values: BPC = ceil(CH_W/8); FRAME_BYTES = 2 + N_CH*BPC + 1.
- Reset state: all outputs 0; FSM IDLE; seq=0; bank=0; tick counter 0.
- Reset mid-frame: frame abandoned, STAT_ADDR not written; the host keeps the previous bank.
- Tick counter:
  - When en=1, counts 0..PERIOD_CYC-1 and wraps; tick pulses when count==PERIOD_CYC-1.
  - en=0 forces the count to 0 and suppresses ticks; a frame already in progress completes.
- FSM states:
  - IDLE: on tick -> RD_CTRL.
  - RD_CTRL: ram_addr=CTRL_ADDR, ram_we=0 -> RD_WAIT.
  - RD_WAIT: -> LATCH.
  - LATCH: capture ram_rdata as ctrl and snapshot ch_data into an internal register. If ctrl[0]=1 (pause) -> IDLE with no writes, seq unchanged. Otherwise -> WR_HDR.
  - WR_HDR: writes SYNC_BYTE at base(bank)+0.
  - WR_SEQ: writes seq at base(bank)+1.
  - WR_DATA: N_CH*BPC cycles. Channel 0 first, each channel MSB byte first, zero-extended to BPC*8 bits. Addresses base+2 upward.
  - WR_SUM: writes the checksum at base+FRAME_BYTES-1. Checksum = XOR of the seq byte and all data bytes; SYNC_BYTE is excluded.
  - WR_STAT: writes {bank, seq[6:0]} to STAT_ADDR. Next cycle: frame_done=1, bank toggles, seq increments (wraps 255->0), FSM -> IDLE.
- Write cycles: exactly one byte per cycle with ram_we=1, no gaps. Tick-to-frame_done latency is FRAME_BYTES+5 cycles.
- Snapshot: ch_data changes after LATCH do not affect the frame in progress.
- Tick while busy: the tick is dropped and overrun is set (sticky until Rst); the current frame is unaffected.
- busy=1 in every state other than IDLE.

Optional Feature:
- Macro SFW_CRC8_EN.
- Defined: the checksum byte is CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) over the seq and data bytes, updated one byte per write cycle. Timing is unchanged.
- Undefined: XOR checksum as specified above; no CRC logic is synthesised.

Decomposition:
- Shared package sensor_frame_pkg holds:
  - FSM state enum
  - SYNC_BYTE default
  - CRC8 polynomial constant
  - function computing FRAME_BYTES from N_CH and CH_W
- One sub-module, frame_crc8: byte-step CRC-8 combinational update, instantiated only under SFW_CRC8_EN.

Test Plan:
- XOR frame: defaults; ch_data = 3231,3433,3635,3837,3A39,3C3B,3E3D (ch0..ch6); ctrl=0; en=1.
  - First frame writes A5,00,32,31,34,33,...,3E,3D,0F to 'h10..'h20, then 'h00 to 'h01.
  - frame_done 22 cycles after tick; seq becomes 1.
- Ping-pong: the second frame lands at 'h30..'h40 with status 'h81; the third returns to 'h10 with status 'h02.
- Pause: host sets CTRL byte=01.
  - Next tick: no ram_we apart from the ctrl read, seq held, no frame_done.
  - After clearing CTRL to 00, frames resume.
- Overrun: PERIOD_CYC=10 (less than 22).
  - overrun sets on the first dropped tick and stays set; every frame still writes 17 contiguous bytes plus status.
- Reset mid-frame: assert Rst during the WR_DATA state.
  - All outputs 0 the next cycle; STAT_ADDR not written.
  - The next frame starts at bank 0 with seq=0.
- Odd width: CH_W=12, N_CH=2, ch0=ABC, ch1=123.
  - Data bytes are 0A,BC,01,23; FRAME_BYTES=7.
  - With SFW_CRC8_EN, the checksum equals a reference CRC-8 of {seq,0A,BC,01,23}.
